rsel_pkt_fifo: RTL

RSEL_PKT_FIFO -- requirements
Module: rsel_pkt_fifo

---
 rtl/rsel_pkt_fifo_pkg.sv | 20 ++
 rtl/rsel_pkt_fifo.sv | 117 +++++++++++
 2 files changed

// File: rtl/rsel_pkt_fifo_pkg.sv
// Shared packet layout for the RSel output stage and its neighbours.
// Field widths, the 94-bit packed packet struct and the total width live here.
package rsel_pkt_fifo_pkg;

    localparam int NODE_W    = 16;
    localparam int GEN_W     = 12;
    localparam int OPR_W     = 32;
    localparam int MEM_WEN_W = 2;
    localparam int PKT_W     = NODE_W + GEN_W + OPR_W + OPR_W + MEM_WEN_W;

    // Node is the most significant field of the packed entry.
    typedef struct packed {
        logic [NODE_W-1:0]    node;
        logic [GEN_W-1:0]     gen;
        logic [OPR_W-1:0]     opr0;
        logic [OPR_W-1:0]     opr1;
        logic [MEM_WEN_W-1:0] mem_wen;
    } rsel_pkt_t;

endpackage

// File: rtl/rsel_pkt_fifo.sv
// First-word fall-through packet FIFO between RSel and its consumer.
// Full-FIFO pushes are refused even when a pop happens in the same cycle.
module rsel_pkt_fifo
    import rsel_pkt_fifo_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk_i_rpf,
    input  logic                         rst_i_rpf,
    input  logic                         valid_i_rpf,
    output logic                         ready_o_rpf,
    input  logic [NODE_W-1:0]            node_i_rpf,
    input  logic [GEN_W-1:0]             gen_i_rpf,
    input  logic [OPR_W-1:0]             opr0_i_rpf,
    input  logic [OPR_W-1:0]             opr1_i_rpf,
    input  logic [MEM_WEN_W-1:0]         mem_wen_i_rpf,
    output logic                         valid_o_rpf,
    input  logic                         ready_i_rpf,
    output logic [NODE_W-1:0]            node_o_rpf,
    output logic [GEN_W-1:0]             gen_o_rpf,
    output logic [OPR_W-1:0]             opr0_o_rpf,
    output logic [OPR_W-1:0]             opr1_o_rpf,
    output logic [MEM_WEN_W-1:0]         mem_wen_o_rpf,
    output logic [$clog2(DEPTH):0]       count_o_rpf
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
    localparam logic [PW-1:0] PTR_LAST   = PW'(DEPTH - 1);
    localparam logic [PW-1:0] PTR_ONE    = PW'(1);

    rsel_pkt_t       mem_r [DEPTH];
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;

    logic [PW-1:0]   wr_ptr_nxt_s;
    logic [PW-1:0]   rd_ptr_nxt_s;
    logic [CW-1:0]   count_nxt_s;
    logic            push_s;
    logic            pop_s;
    rsel_pkt_t       pkt_in_s;
    rsel_pkt_t       head_s;

    // Handshake flags come only from the registered count, so ready never sees ready_i.
    assign ready_o_rpf = (count_r < COUNT_FULL);
    assign valid_o_rpf = (count_r != {CW{1'b0}});
    assign push_s      = valid_i_rpf & ready_o_rpf;
    assign pop_s       = valid_o_rpf & ready_i_rpf;

    assign pkt_in_s = '{node:    node_i_rpf,
                        gen:     gen_i_rpf,
                        opr0:    opr0_i_rpf,
                        opr1:    opr1_i_rpf,
                        mem_wen: mem_wen_i_rpf};

    assign head_s        = mem_r[rd_ptr_r];
    assign node_o_rpf    = head_s.node;
    assign gen_o_rpf     = head_s.gen;
    assign opr0_o_rpf    = head_s.opr0;
    assign opr1_o_rpf    = head_s.opr1;
    assign mem_wen_o_rpf = head_s.mem_wen;
    assign count_o_rpf   = count_r;

    // Next pointer and occupancy values, wrapping pointers at DEPTH-1.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count_r;
        if (push_s) begin
            if (wr_ptr_r == PTR_LAST) begin
                wr_ptr_nxt_s = {PW{1'b0}};
            end else begin
                wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
            end
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (pop_s) begin
            if (rd_ptr_r == PTR_LAST) begin
                rd_ptr_nxt_s = {PW{1'b0}};
            end else begin
                rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
            end
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + COUNT_ONE;
            2'b01:   count_nxt_s = count_r - COUNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointer and occupancy registers; reset discards any held packets at once.
    always_ff @(posedge clk_i_rpf or posedge rst_i_rpf) begin
        if (rst_i_rpf) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
        end
    end

    // Packet storage is deliberately left out of reset.
    always_ff @(posedge clk_i_rpf) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= pkt_in_s;
        end
    end

endmodule
